serial_rx: RTL and testbench
============================

# serial_rx

UART receiver (8N1) that sits directly upstream of `message_printer`. It deserialises the board's serial input line into bytes and presents each byte as `rx_data` with a one-cycle `new_rx_data` strobe, matching that consumer's input contract. It also flags framing errors so the command layer can discard corrupted traffic.

## Interface
- `CLK_PER_BIT`, 100: clock cycles per serial bit (50 MHz / 500 kbaud); legal range 8..65535, even values only.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `rx`  in  1  raw serial line, asynchronous to `clk`; idles high.
- `rx_data`  out  8  last received byte, LSB first on the wire; holds its value until the next good byte.
- `new_rx_data`  out  1  one-cycle pulse: `rx_data` is valid and new.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low and the byte was discarded.

## Operation
- `rx` passes through a 2-FF synchronizer; the synchronizer flops reset to 1. All logic below uses the synchronized signal `rxs`.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on `rxs`==0 go to START and clear the counter.
  - START: count to CLK_PER_BIT/2−1, then sample. If `rxs`==0, go to DATA with the counter cleared and bit index 0. If `rxs`==1, it was a glitch: go to IDLE with no output.
  - DATA: every CLK_PER_BIT cycles, sample `rxs` into shift-register bit [index]. After index 7, go to STOP.
  - STOP: after CLK_PER_BIT cycles, sample. If 1, load `rx_data` from the shift register, pulse `new_rx_data`, and go to IDLE. If 0, pulse `frame_err`, leave `rx_data` unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1 (this covers a break condition), then go to IDLE.
- Counter width is $clog2(CLK_PER_BIT). The counter wraps to 0 at CLK_PER_BIT−1. Bit index is 3 bits.
- `new_rx_data` and `frame_err` are never asserted in the same cycle.
- No backpressure: the consumer must accept each byte within one frame time. A new byte overwrites `rx_data`.

## Timing
- Reset values: `rx_data`=0x00, `new_rx_data`=0, `frame_err`=0, state=IDLE, counter=0, shift register=0.
- Reset mid-frame: return to IDLE immediately with no pulse. After release, a line still low mid-frame is treated as a start edge. This is accepted behaviour.
- Sampling points, with t0 = the first cycle `rxs`==0 in IDLE:
  - Start bit sampled at t0+CLK_PER_BIT/2.
  - Data bit k sampled at t0+CLK_PER_BIT/2+(k+1)·CLK_PER_BIT.
  - Stop bit sampled at t0+CLK_PER_BIT/2+9·CLK_PER_BIT.
- `new_rx_data` / `frame_err` are registered and appear the cycle after the stop sample.
- End-to-end latency from the `rx` falling edge to the strobe: 2 (synchronizer) + 9.5·CLK_PER_BIT + 1 cycles.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge arriving half a bit later is caught. Tolerated baud mismatch is ±4%.

## Structure
- Shared package `serial_pkg`:
  - State enum `rx_state_t`.
  - Constant `SERIAL_BITS`=8.
  - Default `CLK_PER_BIT`=100, shared with the TX side.
- Sub-module `sync_2ff` (1-bit, reset value parameter). Reused by the TX busy path.

## Test plan
All scenarios use CLK_PER_BIT=16 and `rx` driven from a bit-accurate bench task.
- Send 0xB1 -> exactly one `new_rx_data` pulse at t0+2+152+1, with `rx_data`=0xB1 and `frame_err`=0.
- Send "h" (0x68), then 0x00 and 0xFF back-to-back with no idle gap -> three pulses, each CLK_PER_BIT·10 apart, with values 0x68, 0x00, 0xFF.
- Drive a 4-cycle low glitch on idle `rx` -> no pulse; state returns to IDLE; a following 0x01 is received correctly.
- Frame 0xA5 with the stop bit low, then hold `rx` low for 40 bits -> one `frame_err` pulse, `rx_data` keeps its prior value, no `new_rx_data`. After `rx` returns high, 0x3C is received correctly.
- Assert `rst` low during data bit 4 of 0x55 -> outputs return to reset values asynchronously with no pulse. After release and an idle line, 0xC3 is received correctly.
- Run with CLK_PER_BIT=100 and the bench bit period ±3% -> 0x5A is received correctly in both cases.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial RX/TX blocks: frame size, default bit
// period and the receiver state encoding.
package serial_pkg;

  // Data bits per frame (8N1).
  localparam int SERIAL_BITS = 8;

  // Default clock cycles per serial bit: 50 MHz / 500 kbaud.
  localparam int DEFAULT_CLK_PER_BIT = 100;

  // Receiver state machine states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// The reset value is a parameter so an idle-high line does not look like
// a start edge when reset is released.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver. Samples each bit at its centre, delivers good bytes
// with a one-cycle new_rx_data strobe and flags a low stop bit with a
// one-cycle frame_err strobe (the byte is discarded).
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [SERIAL_BITS-1:0] rx_data,
  output logic                   new_rx_data,
  output logic                   frame_err
);

  localparam int            CW       = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(SERIAL_BITS - 1);

  logic                   rxs;
  rx_state_t              state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [2:0]             idx_reg, idx_next;
  logic [SERIAL_BITS-1:0] sr_reg, sr_next;
  logic [SERIAL_BITS-1:0] data_reg, data_next;
  logic                   new_reg, new_next;
  logic                   ferr_reg, ferr_next;

  // The serial line idles high, so the synchronizer resets to 1.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      sr_reg    <= '0;
      data_reg  <= '0;
      new_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sr_reg    <= sr_next;
      data_reg  <= data_next;
      new_reg   <= new_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state and datapath: half a bit to the start-bit centre, then one
  // full bit period between each later sample. IDLE is re-entered at mid-stop
  // so a back-to-back start edge half a bit later is not missed.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sr_next    = sr_reg;
    data_next  = data_reg;
    new_next   = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (!rxs) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            // Line went back high before the bit centre: a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next          = '0;
          sr_next[idx_reg]  = rxs;
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            data_next  = sr_reg;
            new_next   = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // Hold off through a break until the line returns to idle.
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data     = data_reg;
  assign new_rx_data = new_reg;
  assign frame_err   = ferr_reg;

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: drives bit-accurate 8N1 frames into two
// instances (16 and 100 clocks per bit) and compares every strobe against
// a frame-level reference model (expected byte, error flag, strobe cycle).
module tb_serial_rx;

  localparam int C16  = 16;
  localparam int C100 = 100;

  typedef struct packed {
    logic [31:0] t;
    logic [7:0]  d;
    logic        ferr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst16, rst100;
  logic       rx16, rx100;
  logic [7:0] data16, data100;
  logic       new16, new100, ferr16, ferr100;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  ev_t         evq16[$];
  ev_t         evq100[$];
  logic [7:0]  exp_data16 = 8'h00;

  serial_rx #(.CLK_PER_BIT(C16)) dut16 (
    .clk(clk), .rst(rst16), .rx(rx16),
    .rx_data(data16), .new_rx_data(new16), .frame_err(ferr16)
  );

  serial_rx #(.CLK_PER_BIT(C100)) dut100 (
    .clk(clk), .rst(rst100), .rx(rx100),
    .rx_data(data100), .new_rx_data(new100), .frame_err(ferr100)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every strobe with its cycle; the two strobes must never coincide.
  always @(negedge clk) begin
    if (new16 || ferr16) begin
      evq16.push_back({cyc, data16, ferr16});
      tests++;
      if (new16 && ferr16) begin
        fails++;
        $display("FAIL strobe_exclusive16 cyc=%0d new=%b ferr=%b required not both", cyc, new16, ferr16);
      end
    end
    if (new100 || ferr100) begin
      evq100.push_back({cyc, data100, ferr100});
      tests++;
      if (new100 && ferr100) begin
        fails++;
        $display("FAIL strobe_exclusive100 cyc=%0d new=%b ferr=%b required not both", cyc, new100, ferr100);
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: strobe is visible 2 sync cycles + 9.5 bit periods + 1 register
  // cycle after the cycle in which rx fell.
  function automatic int unsigned exp_time(input int unsigned fall, input int c);
    return fall + 32'(2 + 9 * c + c / 2 + 1);
  endfunction

  task automatic set_rx(input bit big, input logic v);
    if (big) rx100 = v;
    else rx16 = v;
  endtask

  // Called at a negedge; returns at a negedge right after the stop bit ends.
  task automatic send_frame(input bit big, input logic [7:0] b, input bit stop_bit,
                            input int bit_cyc, output int unsigned fall);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    fall  = cyc;
    for (int i = 0; i < 10; i++) begin
      set_rx(big, frame[i]);
      repeat (bit_cyc) @(negedge clk);
    end
    set_rx(big, 1'b1);
  endtask

  task automatic test_reset();
    rst16 = 1'b0; rst100 = 1'b0; rx16 = 1'b1; rx100 = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (data16 !== 8'h00) begin fails++; $display("FAIL reset_data got=%h want=00", data16); end
    tests++;
    if (new16 !== 1'b0 || ferr16 !== 1'b0) begin
      fails++; $display("FAIL reset_strobes got new=%b ferr=%b want 0 0", new16, ferr16);
    end
    tests++;
    if (data100 !== 8'h00 || new100 !== 1'b0 || ferr100 !== 1'b0) begin
      fails++; $display("FAIL reset_dut100 got data=%h new=%b ferr=%b want 00 0 0", data100, new100, ferr100);
    end
    rst16 = 1'b1; rst100 = 1'b1;
    repeat (2 * C16) @(negedge clk);
    tests++;
    if (evq16.size() !== 0) begin fails++; $display("FAIL reset_idle_events got=%0d want=0", evq16.size()); end
  endtask

  task automatic test_single();
    int unsigned fall;
    evq16.delete();
    send_frame(1'b0, 8'hB1, 1'b1, C16, fall);
    repeat (C16) @(negedge clk);
    exp_data16 = 8'hB1;
    tests++;
    if (evq16.size() !== 1) begin
      fails++; $display("FAIL single_count got=%0d want=1", evq16.size());
    end else begin
      tests++;
      if (evq16[0] !== {exp_time(fall, C16), 8'hB1, 1'b0}) begin
        fails++;
        $display("FAIL single_event got t=%0d d=%h ferr=%b want t=%0d d=b1 ferr=0",
                 evq16[0].t, evq16[0].d, evq16[0].ferr, exp_time(fall, C16));
      end
    end
    tests++;
    if (data16 !== 8'hB1) begin fails++; $display("FAIL single_hold got=%h want=b1", data16); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals[3];
    int unsigned falls[3];
    int unsigned f;
    vals = '{8'h68, 8'h00, 8'hFF};
    evq16.delete();
    for (int i = 0; i < 3; i++) begin
      send_frame(1'b0, vals[i], 1'b1, C16, f);
      falls[i] = f;
    end
    repeat (C16) @(negedge clk);
    exp_data16 = 8'hFF;
    tests++;
    if (evq16.size() !== 3) begin
      fails++; $display("FAIL b2b_count got=%0d want=3", evq16.size());
    end
    for (int i = 0; i < 3 && i < evq16.size(); i++) begin
      tests++;
      if (evq16[i] !== {exp_time(falls[i], C16), vals[i], 1'b0}) begin
        fails++;
        $display("FAIL b2b_event%0d got t=%0d d=%h ferr=%b want t=%0d d=%h ferr=0",
                 i, evq16[i].t, evq16[i].d, evq16[i].ferr, exp_time(falls[i], C16), vals[i]);
      end
      if (i > 0) begin
        tests++;
        if (evq16[i].t - evq16[i-1].t !== 32'(10 * C16)) begin
          fails++;
          $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, evq16[i].t - evq16[i-1].t, 10 * C16);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int unsigned fall;
    evq16.delete();
    rx16 = 1'b0;
    repeat (4) @(negedge clk);
    rx16 = 1'b1;
    repeat (2 * C16) @(negedge clk);
    tests++;
    if (evq16.size() !== 0) begin fails++; $display("FAIL glitch_events got=%0d want=0", evq16.size()); end
    send_frame(1'b0, 8'h01, 1'b1, C16, fall);
    repeat (C16) @(negedge clk);
    exp_data16 = 8'h01;
    tests++;
    if (evq16.size() !== 1 || evq16[0] !== {exp_time(fall, C16), 8'h01, 1'b0}) begin
      fails++;
      $display("FAIL glitch_next_byte got n=%0d first=%h want n=1 t=%0d d=01 ferr=0",
               evq16.size(), (evq16.size() > 0) ? evq16[0] : '0, exp_time(fall, C16));
    end
  endtask

  task automatic test_frame_err();
    int unsigned fall;
    logic [7:0]  prior;
    prior = exp_data16;
    evq16.delete();
    send_frame(1'b0, 8'hA5, 1'b0, C16, fall);
    rx16 = 1'b0;
    repeat (40 * C16) @(negedge clk);
    tests++;
    if (evq16.size() !== 1 || evq16[0] !== {exp_time(fall, C16), prior, 1'b1}) begin
      fails++;
      $display("FAIL ferr_event got n=%0d first=%h want n=1 t=%0d d=%h ferr=1",
               evq16.size(), (evq16.size() > 0) ? evq16[0] : '0, exp_time(fall, C16), prior);
    end
    tests++;
    if (data16 !== prior) begin fails++; $display("FAIL ferr_data_kept got=%h want=%h", data16, prior); end
    rx16 = 1'b1;
    repeat (2 * C16) @(negedge clk);
    evq16.delete();
    send_frame(1'b0, 8'h3C, 1'b1, C16, fall);
    repeat (C16) @(negedge clk);
    exp_data16 = 8'h3C;
    tests++;
    if (evq16.size() !== 1 || evq16[0] !== {exp_time(fall, C16), 8'h3C, 1'b0}) begin
      fails++;
      $display("FAIL ferr_recover got n=%0d first=%h want n=1 t=%0d d=3c ferr=0",
               evq16.size(), (evq16.size() > 0) ? evq16[0] : '0, exp_time(fall, C16));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0]  frame;
    int unsigned fall;
    frame = {1'b1, 8'h55, 1'b0};
    evq16.delete();
    for (int i = 0; i < 5; i++) begin
      rx16 = frame[i];
      repeat (C16) @(negedge clk);
    end
    rx16 = frame[5];
    repeat (C16 / 2) @(negedge clk);
    #2 rst16 = 1'b0;
    #1;
    tests++;
    if (data16 !== 8'h00) begin fails++; $display("FAIL midreset_data got=%h want=00", data16); end
    tests++;
    if (new16 !== 1'b0 || ferr16 !== 1'b0) begin
      fails++; $display("FAIL midreset_strobes got new=%b ferr=%b want 0 0", new16, ferr16);
    end
    exp_data16 = 8'h00;
    rx16 = 1'b1;
    repeat (3) @(negedge clk);
    rst16 = 1'b1;
    repeat (2 * C16) @(negedge clk);
    tests++;
    if (evq16.size() !== 0 || data16 !== 8'h00) begin
      fails++; $display("FAIL midreset_quiet got n=%0d data=%h want n=0 data=00", evq16.size(), data16);
    end
    send_frame(1'b0, 8'hC3, 1'b1, C16, fall);
    repeat (C16) @(negedge clk);
    exp_data16 = 8'hC3;
    tests++;
    if (evq16.size() !== 1 || evq16[0] !== {exp_time(fall, C16), 8'hC3, 1'b0}) begin
      fails++;
      $display("FAIL midreset_recover got n=%0d first=%h want n=1 t=%0d d=c3 ferr=0",
               evq16.size(), (evq16.size() > 0) ? evq16[0] : '0, exp_time(fall, C16));
    end
  endtask

  task automatic test_random();
    ev_t         exp_q[$];
    int unsigned fall;
    logic [7:0]  b;
    bit          sb;
    int          gap;
    evq16.delete();
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(1'b0, b, sb, C16, fall);
      exp_q.push_back({exp_time(fall, C16), sb ? b : exp_data16, !sb});
      if (sb) exp_data16 = b;
      // After a framing error the line must return high before the next start.
      gap = sb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      rx16 = 1'b1;
      repeat (gap * C16) @(negedge clk);
    end
    repeat (C16) @(negedge clk);
    tests++;
    if (evq16.size() !== exp_q.size()) begin
      fails++; $display("FAIL random_count got=%0d want=%0d", evq16.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < evq16.size(); i++) begin
      tests++;
      if (evq16[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL random_event%0d got t=%0d d=%h ferr=%b want t=%0d d=%h ferr=%b",
                 i, evq16[i].t, evq16[i].d, evq16[i].ferr, exp_q[i].t, exp_q[i].d, exp_q[i].ferr);
      end
    end
  endtask

  task automatic test_baud_mismatch();
    int          bcs[2];
    int unsigned fall;
    bcs = '{97, 103};
    tests++;
    if (evq100.size() !== 0) begin fails++; $display("FAIL baud_idle got=%0d want=0", evq100.size()); end
    for (int k = 0; k < 2; k++) begin
      evq100.delete();
      send_frame(1'b1, 8'h5A, 1'b1, bcs[k], fall);
      repeat (2 * C100) @(negedge clk);
      tests++;
      if (evq100.size() !== 1 || evq100[0].d !== 8'h5A || evq100[0].ferr !== 1'b0) begin
        fails++;
        $display("FAIL baud_%0d got n=%0d first=%h want n=1 d=5a ferr=0",
                 bcs[k], evq100.size(), (evq100.size() > 0) ? evq100[0] : '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random();
    test_baud_mismatch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
